// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the generator and its renderers
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  pix_en,
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, blanking, delayed sync and frame markers
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } h_region_t;

  logic [9:0] hc;
  logic [9:0] vc;
  logic [7:0] frame_cnt;
  h_region_t  h_region;
  logic       hs_raw;
  logic       vs_raw;
  logic       hs_out;
  logic       vs_out;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (vga.pix_en) begin
      if (hc == H_MAX) begin
        hc <= '0;
        if (vc == V_MAX) begin
          vc        <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          vc <= vc + 10'd1;
        end
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Line region is a pure decode of hc, so it can never disagree with the counter.
  always_comb begin
    h_region = REG_ACTIVE;
    if (hc >= H_BP_START) begin
      h_region = REG_BACK;
    end else if (hc >= H_SYNC_START) begin
      h_region = REG_SYNC;
    end else if (hc >= H_FP_START) begin
      h_region = REG_FRONT;
    end
  end

  assign hs_raw = (h_region != REG_SYNC);
  assign vs_raw = !((vc >= V_SYNC_START) && (vc < V_SYNC_END));

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs_out = hs_raw;
      assign vs_out = vs_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;

      // Stages reset to inactive so a reset mid-pulse never leaks a truncated sync.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else if (vga.pix_en) begin
          hs_pipe <= SYNC_DELAY'({hs_pipe, hs_raw});
          vs_pipe <= SYNC_DELAY'({vs_pipe, vs_raw});
        end
      end

      assign hs_out = hs_pipe[SYNC_DELAY-1];
      assign vs_out = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.blank       = (h_region == REG_ACTIVE) && (vc < V_ACT_END);
  assign vga.hs          = hs_out;
  assign vga.vs          = vs_out;
  assign vga.line_start  = (hc == 10'd0);
  assign vga.frame_start = (hc == 10'd0) && (vc == 10'd0);
  assign vga.frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a pixel-count model
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n;
  logic pix_en;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   t       = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_d0 ();
  vga_timing_gen_if if_d3 ();
  vga_timing_gen_if if_sm ();

  assign if_def.pix_en = pix_en;
  assign if_d0.pix_en  = pix_en;
  assign if_d3.pix_en  = pix_en;
  assign if_sm.pix_en  = pix_en;

  vga_timing_gen u_def (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_def));
  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d0));
  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d3));
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(2)
  ) u_sm (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_sm));

  // Number of enabled pixel steps since the last reset; everything else follows from it.
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) t <= 0;
    else if (pix_en) t <= t + 1;
  end

  function automatic logic [32:0] model(input int n, input int ha, input int hf, input int hsw,
                                        input int hb, input int va, input int vf, input int vsw,
                                        input int vb, input int d);
    int ht, vt, hc, vc, fc, nd, hcd, vcd;
    logic bl, hsx, vsx, ls, fs;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    hc  = n % ht;
    vc  = (n / ht) % vt;
    fc  = (n / (ht * vt)) % 256;
    bl  = (hc < ha) && (vc < va);
    ls  = (hc == 0);
    fs  = (hc == 0) && (vc == 0);
    hsx = 1'b1;
    vsx = 1'b1;
    if (n >= d) begin
      nd  = n - d;
      hcd = nd % ht;
      vcd = (nd / ht) % vt;
      hsx = !((hcd >= ha + hf) && (hcd < ha + hf + hsw));
      vsx = !((vcd >= va + vf) && (vcd < va + vf + vsw));
    end
    return {10'(hc), 10'(vc), bl, hsx, vsx, ls, fs, 8'(fc)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic check_vec(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  always @(negedge vga_clk) begin
    check_vec("model_def", {if_def.DrawX, if_def.DrawY, if_def.blank, if_def.hs, if_def.vs,
              if_def.line_start, if_def.frame_start, if_def.frame_count},
              model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1));
    check_vec("model_d0", {if_d0.DrawX, if_d0.DrawY, if_d0.blank, if_d0.hs, if_d0.vs,
              if_d0.line_start, if_d0.frame_start, if_d0.frame_count},
              model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0));
    check_vec("model_d3", {if_d3.DrawX, if_d3.DrawY, if_d3.blank, if_d3.hs, if_d3.vs,
              if_d3.line_start, if_d3.frame_start, if_d3.frame_count},
              model(t, 640, 16, 96, 48, 480, 10, 2, 33, 3));
    check_vec("model_sm", {if_sm.DrawX, if_sm.DrawY, if_sm.blank, if_sm.hs, if_sm.vs,
              if_sm.line_start, if_sm.frame_start, if_sm.frame_count},
              model(t, 8, 2, 3, 2, 4, 1, 2, 1, 2));
  end

  initial begin
    logic pb, pb3, ph1, ph0, ph3, pvs;
    int   n_bf, n_hf1, n_hr1, n_hf0, n_hf3, found, last, nfs, nvs, vs_start;

    reset_n = 1'b1;
    pix_en  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("rst_x", if_def.DrawX, 0);
    check("rst_y", if_def.DrawY, 0);
    check("rst_blank", if_def.blank, 1);
    check("rst_line_start", if_def.line_start, 1);
    check("rst_frame_start", if_def.frame_start, 1);
    check("rst_hs", if_def.hs, 1);
    check("rst_vs", if_def.vs, 1);
    check("rst_fc", if_def.frame_count, 0);

    #1 reset_n = 1'b1;
    pix_en = 1'b1;
    check("first_x", if_def.DrawX, 0);
    check("first_frame_start", if_def.frame_start, 1);

    // One full line at defaults: locate the blank and sync edges.
    n_bf = 0; n_hf1 = 0; n_hr1 = 0; n_hf0 = 0; n_hf3 = 0;
    pb = if_def.blank; pb3 = if_d3.blank;
    ph1 = if_def.hs; ph0 = if_d0.hs; ph3 = if_d3.hs;
    for (int c = 0; c < 800; c++) begin
      @(negedge vga_clk);
      if (pb && !if_def.blank) begin n_bf++; check("blank_fall_x", if_def.DrawX, 640); end
      if (pb3 && !if_d3.blank) check("d3_blank_fall_x", if_d3.DrawX, 640);
      if (ph1 && !if_def.hs) begin n_hf1++; check("hs_fall_x_d1", if_def.DrawX, 657); end
      if (!ph1 && if_def.hs) begin n_hr1++; check("hs_rise_x_d1", if_def.DrawX, 753); end
      if (ph0 && !if_d0.hs) begin n_hf0++; check("hs_fall_x_d0", if_d0.DrawX, 656); end
      if (ph3 && !if_d3.hs) begin n_hf3++; check("hs_fall_x_d3", if_d3.DrawX, 659); end
      pb = if_def.blank; pb3 = if_d3.blank;
      ph1 = if_def.hs; ph0 = if_d0.hs; ph3 = if_d3.hs;
    end
    check("line_wrap_x", if_def.DrawX, 0);
    check("line_wrap_y", if_def.DrawY, 1);
    check("line_wrap_ls", if_def.line_start, 1);
    check("n_blank_fall", n_bf, 1);
    check("n_hs_fall_d1", n_hf1, 1);
    check("n_hs_rise_d1", n_hr1, 1);
    check("n_hs_fall_d0", n_hf0, 1);
    check("n_hs_fall_d3", n_hf3, 1);

    // Random pixel-enable pattern, checked continuously against the model.
    repeat (4000) begin
      @(negedge vga_clk);
      #1 pix_en = ($urandom_range(0, 3) != 0);
    end
    pix_en = 1'b1;

    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge vga_clk);
      if (if_def.DrawX == 10'd300) found = 1;
    end
    check("reach_x300", found, 1);
    if (found == 1) begin
      #1 pix_en = 1'b0;
      repeat (5) begin
        @(negedge vga_clk);
        check("hold_x", if_def.DrawX, 300);
        check("hold_hs", if_def.hs, 1);
      end
      #1 pix_en = 1'b1;
      @(negedge vga_clk);
      check("resume_x", if_def.DrawX, 301);
    end

    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      @(negedge vga_clk);
      if (if_def.DrawX == 10'd700) found = 1;
    end
    check("reach_x700", found, 1);
    if (found == 1) begin
      check("hs_low_at_700", if_def.hs, 0);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_x", if_def.DrawX, 0);
      check("async_rst_y", if_def.DrawY, 0);
      check("async_rst_hs", if_def.hs, 1);
      check("async_rst_vs", if_def.vs, 1);
      check("async_rst_fc", if_def.frame_count, 0);
      @(negedge vga_clk);
      #1 reset_n = 1'b1;
      @(negedge vga_clk);
      check("post_rst_x", if_def.DrawX, 1);
      check("post_rst_y", if_def.DrawY, 0);
      check("post_rst_hs", if_def.hs, 1);
    end

    // Whole-frame behaviour on the reduced raster: 15 x 8 = 120 pixels per frame.
    @(negedge vga_clk);
    #1 reset_n = 1'b0;
    @(negedge vga_clk);
    #1 reset_n = 1'b1;
    last = 0; nfs = 0; nvs = 0; vs_start = 0;
    pvs = if_sm.vs;
    for (int c = 1; c <= 256 * 120 + 10 && nfs < 256; c++) begin
      @(negedge vga_clk);
      if (if_sm.frame_start) begin
        nfs++;
        check("fs_period", c - last, 120);
        last = c;
        if (nfs == 1) check("fc_first_wrap", if_sm.frame_count, 1);
        if (nfs == 256) check("fc_wrap_256", if_sm.frame_count, 0);
      end
      if (pvs && !if_sm.vs) begin
        if (nvs == 0) begin
          check("vs_fall_y", if_sm.DrawY, 5);
          check("vs_fall_x", if_sm.DrawX, 2);
        end
        nvs++;
        vs_start = c;
      end
      if (!pvs && if_sm.vs) check("vs_width", c - vs_start, 30);
      pvs = if_sm.vs;
    end
    check("frames_seen", nfs, 256);
    check("vs_pulses", nvs, 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
